// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-state responder slice.
// Holds the game state codes, the controller command (flag) codes,
// field width constants and a small saturating-increment helper.
package game_pkg;

  localparam int FLAG_W  = 4;
  localparam int STATE_W = 3;
  localparam int STAGE_W = 2;
  localparam int LIVES_W = 2;
  localparam int SCORE_W = 10;
  localparam int TIMER_W = 7;

  // Game state codes; 2, 6 and 7 are unused.
  typedef enum logic [STATE_W-1:0] {
    ST_READY = 3'd0,
    ST_PLAY  = 3'd1,
    ST_OVER  = 3'd3,
    ST_SCLR  = 3'd4,
    ST_GCLR  = 3'd5
  } game_state_e;

  // Command codes issued by the main game FSM.
  localparam logic [FLAG_W-1:0] F_SCORE  = 4'b0001;
  localparam logic [FLAG_W-1:0] F_LIFE   = 4'b0010;
  localparam logic [FLAG_W-1:0] F_RESUME = 4'b0101;
  localparam logic [FLAG_W-1:0] F_READY  = 4'b1000;
  localparam logic [FLAG_W-1:0] F_SCLR   = 4'b1100;
  localparam logic [FLAG_W-1:0] F_OVER   = 4'b1101;
  localparam logic [FLAG_W-1:0] F_GCLR   = 4'b1110;

  localparam logic [STAGE_W-1:0] STAGE_LAST = 2'd3;

  // Score increment that sticks at the limit instead of wrapping.
  function automatic logic [SCORE_W-1:0] score_sat_inc(
    input logic [SCORE_W-1:0] value,
    input logic [SCORE_W-1:0] limit
  );
    return (value < limit) ? (value + 10'd1) : limit;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// sec_timer: 1 Hz prescaler plus 7-bit seconds down-counter.
// Ports:
//   clk_1mhz     in   system clock
//   rst          in   synchronous active-high reset
//   load         in   load load_val, clear prescaler (wins over everything)
//   load_val     in   seconds to load; loading 0 leaves the timer stopped
//   stop         in   stop counting, timer value frozen
//   timer        out  seconds remaining
//   running      out  counting down
//   sec_posedge  out  one-cycle pulse on every elapsed second
module sec_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 1000000
) (
  input  logic               clk_1mhz,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               stop,
  output logic [TIMER_W-1:0] timer,
  output logic               running,
  output logic               sec_posedge
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);

  logic [PRESC_W-1:0] presc_r;
  logic [TIMER_W-1:0] timer_r;
  logic               running_r;
  logic               sec_r;

  // Prescaler and down-counter; a load in the wrap cycle suppresses the tick.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      presc_r   <= PRESC_ZERO;
      timer_r   <= 7'd0;
      running_r <= 1'b0;
      sec_r     <= 1'b0;
    end else if (load) begin
      presc_r   <= PRESC_ZERO;
      timer_r   <= load_val;
      running_r <= (load_val != 7'd0);
      sec_r     <= 1'b0;
    end else if (stop) begin
      presc_r   <= PRESC_ZERO;
      running_r <= 1'b0;
      sec_r     <= 1'b0;
    end else if (running_r) begin
      if (presc_r == PRESC_LAST) begin
        presc_r   <= PRESC_ZERO;
        sec_r     <= 1'b1;
        timer_r   <= timer_r - 7'd1;
        // Reaching zero stops the counter in the same cycle.
        running_r <= (timer_r != 7'd1);
      end else begin
        presc_r <= presc_r + PRESC_ONE;
        sec_r   <= 1'b0;
      end
    end else begin
      presc_r <= PRESC_ZERO;
      sec_r   <= 1'b0;
    end
  end

  assign timer       = timer_r;
  assign running     = running_r;
  assign sec_posedge = sec_r;

endmodule

// File: rtl/game_state_responder.sv
// game_state_responder: executes controller commands (flag + trig edge),
// tracks game state, stage, lives and score, owns the seconds timer and
// acknowledges every accepted command with a one-cycle done pulse.
// Ports:
//   clk_1mhz       in   system clock
//   rst            in   synchronous active-high reset
//   flag[3:0]      in   command code
//   trig           in   command strobe, acted on at its rising edge
//   done           out  one-cycle acknowledge (also for ignored commands)
//   sec_posedge    out  one pulse per elapsed second while running
//   timer_running  out  timer counting down
//   timer[6:0]     out  seconds remaining
//   state[2:0]     out  game state code
//   stage[1:0]     out  current stage
//   lives[1:0]     out  remaining lives
//   score[9:0]     out  current score
module game_state_responder
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 1000000,
  parameter int COUNTDOWN_S  = 3,
  parameter int STAGE_TIME_S = 30,
  parameter int INIT_LIVES   = 3,
  parameter int SCORE_MAX    = 999
) (
  input  logic         clk_1mhz,
  input  logic         rst,
  input  logic [3:0]   flag,
  input  logic         trig,
  output logic         done,
  output logic         sec_posedge,
  output logic         timer_running,
  output logic [6:0]   timer,
  output logic [2:0]   state,
  output logic [1:0]   stage,
  output logic [1:0]   lives,
  output logic [9:0]   score
);

  localparam logic [TIMER_W-1:0] COUNT_VAL  = TIMER_W'(COUNTDOWN_S);
  localparam logic [TIMER_W-1:0] STAGE_VAL  = TIMER_W'(STAGE_TIME_S);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_LIM  = SCORE_W'(SCORE_MAX);

  game_state_e        state_r, state_nxt_s;
  logic [STAGE_W-1:0] stage_r, stage_nxt_s;
  logic [LIVES_W-1:0] lives_r, lives_nxt_s;
  logic [SCORE_W-1:0] score_r, score_nxt_s;
  logic               trig_r;
  logic               done_r;
  logic               accept_s;
  logic               load_s;
  logic [TIMER_W-1:0] load_val_s;
  logic               stop_s;
  logic               running_s;

  assign accept_s = trig & ~trig_r;

  // Next game state and timer control for an accepted command.
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    lives_nxt_s = lives_r;
    score_nxt_s = score_r;
    load_s      = 1'b0;
    load_val_s  = 7'd0;
    stop_s      = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_READY: begin
          case (flag)
            F_RESUME: begin
              load_s     = 1'b1;
              load_val_s = COUNT_VAL;
            end
            F_READY: begin
              // Play only starts once the countdown has run out.
              if (!running_s) begin
                state_nxt_s = ST_PLAY;
                load_s      = 1'b1;
                load_val_s  = STAGE_VAL;
              end else begin
                state_nxt_s = ST_READY;
              end
            end
            default: state_nxt_s = ST_READY;
          endcase
        end
        ST_PLAY: begin
          case (flag)
            F_SCORE: score_nxt_s = score_sat_inc(score_r, SCORE_LIM);
            F_LIFE:  lives_nxt_s = (lives_r != 2'd0) ? (lives_r - 2'd1) : 2'd0;
            F_SCLR: begin
              state_nxt_s = ST_SCLR;
              stop_s      = 1'b1;
            end
            F_OVER: begin
              state_nxt_s = ST_OVER;
              stop_s      = 1'b1;
            end
            F_GCLR: begin
              state_nxt_s = ST_GCLR;
              stop_s      = 1'b1;
            end
            default: state_nxt_s = ST_PLAY;
          endcase
        end
        ST_SCLR: begin
          if (flag == F_READY) begin
            state_nxt_s = ST_READY;
            stage_nxt_s = (stage_r != STAGE_LAST) ? (stage_r + 2'd1) : STAGE_LAST;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_SCLR;
          end
        end
        ST_OVER, ST_GCLR: begin
          if (flag == F_READY) begin
            state_nxt_s = ST_READY;
            stage_nxt_s = 2'd0;
            lives_nxt_s = LIVES_INIT;
            score_nxt_s = 10'd0;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = ST_READY;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Game registers, trig history and acknowledge.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state_r <= ST_READY;
      stage_r <= 2'd0;
      lives_r <= LIVES_INIT;
      score_r <= 10'd0;
      trig_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      stage_r <= stage_nxt_s;
      lives_r <= lives_nxt_s;
      score_r <= score_nxt_s;
      trig_r  <= trig;
      done_r  <= accept_s;
    end
  end

  sec_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_timer (
    .clk_1mhz   (clk_1mhz),
    .rst        (rst),
    .load       (load_s),
    .load_val   (load_val_s),
    .stop       (stop_s),
    .timer      (timer),
    .running    (running_s),
    .sec_posedge(sec_posedge)
  );

  assign timer_running = running_s;
  assign done          = done_r;
  assign state         = state_r;
  assign stage         = stage_r;
  assign lives         = lives_r;
  assign score         = score_r;

endmodule

// File: tb/tb_game_state_responder.sv
// Scoreboard bench for game_state_responder with CLK_HZ=10.
// The driver applies commands to an abstract game model and queues the
// expected response; a negedge monitor checks the timer every cycle from a
// closed-form "seconds since load" model and pops the queue on each done.
module tb_game_state_responder;

  localparam int CLK_HZ  = 10;
  localparam int COUNT   = 3;
  localparam int STAGE_T = 30;
  localparam int INIT_L  = 3;
  localparam int SMAX    = 999;
  localparam int INF     = 32'h7fffffff;

  logic       clk_1mhz = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [3:0] flag = 4'b0000;
  logic       done, sec_posedge, timer_running;
  logic [6:0] timer;
  logic [2:0] state;
  logic [1:0] stage, lives;
  logic [9:0] score;

  game_state_responder #(
    .CLK_HZ(CLK_HZ), .COUNTDOWN_S(COUNT), .STAGE_TIME_S(STAGE_T),
    .INIT_LIVES(INIT_L), .SCORE_MAX(SMAX)
  ) dut (
    .clk_1mhz(clk_1mhz), .rst(rst), .flag(flag), .trig(trig), .done(done),
    .sec_posedge(sec_posedge), .timer_running(timer_running), .timer(timer),
    .state(state), .stage(stage), .lives(lives), .score(score)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  int edge_cnt = 0;
  always @(posedge clk_1mhz) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int acc_edge;
    int st;
    int stg;
    int lv;
    int sc;
  } resp_t;
  resp_t exp_q[$];

  // Abstract game model
  int m_st = 0, m_stg = 0, m_lv = INIT_L, m_sc = 0;
  // Timer segments: loaded with value v at edge s, stopped at edge p
  int cs = 0, cv = 0, cp = INF;
  int ps = 0, pv = 0, pp = INF;
  bit chk_en = 1'b0;
  int last_acc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, edge_cnt);
    end
  endtask

  // Expected timer outputs after edge e, from whole seconds elapsed since load.
  function automatic void exp_timer(input int e, output int t, output int run, output int sec);
    int s, v, p, k, x;
    if (e >= cs) begin s = cs; v = cv; p = cp; end
    else begin s = ps; v = pv; p = pp; end
    k = e - s;
    x = (e >= p) ? (p - 1 - s) : k;
    t = v - x / CLK_HZ;
    if (t < 0) t = 0;
    run = (e < p && t > 0) ? 1 : 0;
    sec = (e < p && k > 0 && (k % CLK_HZ) == 0 && (k / CLK_HZ) <= v) ? 1 : 0;
  endfunction

  function automatic void seg_load(input int a, input int v);
    ps = cs; pv = cv; pp = cp;
    cs = a; cv = v; cp = INF;
  endfunction

  function automatic void seg_stop(input int a);
    if (cp > a) cp = a;
  endfunction

  // Monitor: timer every cycle, game fields whenever done is presented.
  always @(negedge clk_1mhz) begin : monitor
    int t_e, r_e, s_e;
    resp_t r;
    if (chk_en) begin
      exp_timer(edge_cnt, t_e, r_e, s_e);
      check("timer", int'(timer), t_e);
      check("timer_running", int'(timer_running), r_e);
      check("sec_posedge", int'(sec_posedge), s_e);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_without_cmd", int'(done), 0);
        end else begin
          r = exp_q.pop_front();
          check("done_edge", edge_cnt, r.acc_edge);
          check("state", int'(state), r.st);
          check("stage", int'(stage), r.stg);
          check("lives", int'(lives), r.lv);
          check("score", int'(score), r.sc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_1mhz);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input int hold);
    int a, t_e, r_e, s_e;
    resp_t r;
    @(posedge clk_1mhz);
    #1;
    a = edge_cnt + 1;
    exp_timer(edge_cnt, t_e, r_e, s_e);
    case (m_st)
      0: begin
        if (f == 4'b0101) seg_load(a, COUNT);
        else if (f == 4'b1000 && r_e == 0) begin m_st = 1; seg_load(a, STAGE_T); end
      end
      1: begin
        if (f == 4'b0001) m_sc = (m_sc < SMAX) ? m_sc + 1 : SMAX;
        else if (f == 4'b0010) m_lv = (m_lv > 0) ? m_lv - 1 : 0;
        else if (f == 4'b1100) begin m_st = 4; seg_stop(a); end
        else if (f == 4'b1101) begin m_st = 3; seg_stop(a); end
        else if (f == 4'b1110) begin m_st = 5; seg_stop(a); end
      end
      4: begin
        if (f == 4'b1000) begin
          m_st = 0; m_stg = (m_stg < 3) ? m_stg + 1 : 3; seg_load(a, 0);
        end
      end
      3, 5: begin
        if (f == 4'b1000) begin
          m_st = 0; m_stg = 0; m_lv = INIT_L; m_sc = 0; seg_load(a, 0);
        end
      end
      default: ;
    endcase
    r.acc_edge = a; r.st = m_st; r.stg = m_stg; r.lv = m_lv; r.sc = m_sc;
    exp_q.push_back(r);
    last_acc = a;
    flag = f;
    trig = 1'b1;
    repeat (hold) @(posedge clk_1mhz);
    #1;
    trig = 1'b0;
    flag = 4'($urandom());
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk_1mhz);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    trig = 1'b0;
    repeat (cycles) @(posedge clk_1mhz);
    #1;
    rst = 1'b0;
    m_st = 0; m_stg = 0; m_lv = INIT_L; m_sc = 0;
    cs = edge_cnt; cv = 0; cp = INF;
    ps = edge_cnt; pv = 0; pp = INF;
    exp_q.delete();
    check("rst_state", int'(state), 0);
    check("rst_stage", int'(stage), 0);
    check("rst_lives", int'(lives), INIT_L);
    check("rst_score", int'(score), 0);
    check("rst_timer", int'(timer), 0);
    check("rst_running", int'(timer_running), 0);
    check("rst_sec", int'(sec_posedge), 0);
    check("rst_done", int'(done), 0);
    chk_en = 1'b1;
  endtask

  logic [3:0] codes [7] = '{4'b0001, 4'b0010, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1110};

  initial begin
    int sel;
    logic [3:0] f;
    do_reset(3);
    // Countdown then play
    issue(4'b0101, 1);
    idle(35);
    issue(4'b1000, 1);
    issue(4'b0001, 5);
    repeat (4) issue(4'b0010, 1);
    // Stage clear and back to READY, then ignored 1000 while counting down
    issue(4'b1100, 1);
    issue(4'b1000, 1);
    issue(4'b0101, 1);
    issue(4'b1000, 1);
    idle(35);
    issue(4'b1000, 1);
    // Score saturation, game over, new game
    repeat (1002) issue(4'b0001, 1);
    issue(4'b1101, 1);
    issue(4'b1000, 1);
    // Countdown reload landing exactly on a prescaler wrap
    issue(4'b0101, 1);
    while (edge_cnt < last_acc + CLK_HZ - 2) idle(1);
    issue(4'b0101, 1);
    idle(35);
    issue(4'b1000, 1);
    idle(50);
    do_reset(1);
    // Stage saturation at 3, then game clear
    repeat (4) begin
      issue(4'b1000, 1);
      issue(4'b1100, 1);
      issue(4'b1000, 1);
    end
    issue(4'b1000, 1);
    issue(4'b1110, 1);
    issue(4'b1000, 1);
    // Randomized command stream
    repeat (150) begin
      idle(int'($urandom_range(0, 40)));
      if ($urandom_range(0, 9) == 0) idle(320);
      sel = int'($urandom_range(0, 7));
      if (sel == 7) f = 4'($urandom());
      else f = codes[sel];
      issue(f, int'($urandom_range(1, 4)));
    end
    idle(5);
    check("pending_responses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
